stp_rx_ctrl: RTL and testbench

- Receive-side sequencer for the serial-to-parallel shift register.
- Detects the start bit on an idle-high serial line and times each bit with an internal bit timer.
- Pulses the register's `shift_enable` once per data bit at mid-bit.
- Checks the stop bit, and optional parity, then issues `load_buffer` to the receive buffer.
- Manages the `data_ready` / `data_read` handshake with the consumer, plus framing and overrun flags.

---
 rtl/stp_rx_pkg.sv | 20 ++
 rtl/rx_bit_timer.sv | 40 ++++
 rtl/stp_rx_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_stp_rx_ctrl.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/stp_rx_pkg.sv
// Shared types and default constants for the serial receive sequencer.
// The PARITY state only exists when RX_PARITY_EN is defined.
package stp_rx_pkg;

  localparam int RX_CLKS_PER_BIT  = 10;
  localparam int RX_SAMPLE_OFFSET = 4;
  localparam int RX_DATA_BITS     = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START_CHK,
    ST_DATA,
`ifdef RX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP,
    ST_LOAD
  } rx_state_t;

endpackage

// File: rtl/rx_bit_timer.sv
// Clearable wrapping bit timer: counts 0..CLKS_PER_BIT-1 and flags the
// mid-bit sample point and the last clock of each bit period.
module rx_bit_timer
  import stp_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT  = RX_CLKS_PER_BIT,
  parameter int SAMPLE_OFFSET = RX_SAMPLE_OFFSET
) (
  input  logic clk,
  input  logic n_rst,
  input  logic clear_i,
  output logic sample_strobe_o,
  output logic bit_end_o
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] LAST_CNT = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] SAMP_CNT = TW'(SAMPLE_OFFSET);

  logic [TW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clear_i || cnt_q == LAST_CNT) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign sample_strobe_o = (cnt_q == SAMP_CNT);
  assign bit_end_o       = (cnt_q == LAST_CNT);

endmodule

// File: rtl/stp_rx_ctrl.sv
// Receive sequencer for the serial-to-parallel shift register: start detect,
// mid-bit shift strobes, stop check, buffer handshake. Parity: RX_PARITY_EN.
module stp_rx_ctrl
  import stp_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT  = RX_CLKS_PER_BIT,
  parameter int SAMPLE_OFFSET = RX_SAMPLE_OFFSET,
  parameter int DATA_BITS     = RX_DATA_BITS
`ifdef RX_PARITY_EN
  ,
  parameter bit PARITY_ODD    = 1'b0
`endif
) (
  input  logic clk,
  input  logic n_rst,
  input  logic serial_in,
  input  logic data_read,
  output logic shift_enable,
  output logic load_buffer,
  output logic data_ready,
  output logic framing_error,
  output logic overrun_error,
  output logic parity_error,
  output logic rx_busy
);

  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS);

  rx_state_t     state_q, state_d;
  logic [BW-1:0] bit_cnt_q, bit_cnt_d;
  logic          prev_q;
  logic          armed_q;
  logic          framing_q, framing_d;
  logic          overrun_q, overrun_d;
  logic          ready_q, ready_d;
  logic          sample_strobe, bit_end;
  logic          start_edge;
`ifdef RX_PARITY_EN
  logic          par_acc_q, par_acc_d;
  logic          par_err_q, par_err_d;
`endif

  rx_bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .SAMPLE_OFFSET(SAMPLE_OFFSET)
  ) u_timer (
    .clk            (clk),
    .n_rst          (n_rst),
    .clear_i        (state_q == ST_IDLE || state_q == ST_LOAD),
    .sample_strobe_o(sample_strobe),
    .bit_end_o      (bit_end)
  );

  // armed_q blocks the first post-reset cycle so a line already low is not
  // mistaken for a start edge against the reset value of prev_q.
  assign start_edge = armed_q && prev_q && !serial_in;

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    framing_d    = framing_q;
    overrun_d    = overrun_q;
    ready_d      = ready_q;
    shift_enable = 1'b0;
    load_buffer  = 1'b0;
`ifdef RX_PARITY_EN
    par_acc_d    = par_acc_q;
    par_err_d    = par_err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start_edge) begin
          framing_d = 1'b0;
`ifdef RX_PARITY_EN
          par_err_d = 1'b0;
`endif
          state_d   = ST_START_CHK;
        end
      end
      ST_START_CHK: begin
        if (sample_strobe && serial_in) begin
          state_d = ST_IDLE;
        end else if (bit_end) begin
          bit_cnt_d = '0;
`ifdef RX_PARITY_EN
          par_acc_d = 1'b0;
`endif
          state_d   = ST_DATA;
        end
      end
      ST_DATA: begin
        if (sample_strobe) begin
          shift_enable = 1'b1;
          bit_cnt_d    = bit_cnt_q + 1'b1;
`ifdef RX_PARITY_EN
          par_acc_d    = par_acc_q ^ serial_in;
`endif
        end
        if (bit_end && bit_cnt_q == LAST_BIT) begin
`ifdef RX_PARITY_EN
          state_d = ST_PARITY;
`else
          state_d = ST_STOP;
`endif
        end
      end
`ifdef RX_PARITY_EN
      ST_PARITY: begin
        if (sample_strobe) begin
          par_acc_d = par_acc_q ^ serial_in;
        end
        if (bit_end) begin
          state_d = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (sample_strobe) begin
          if (!serial_in) begin
            framing_d = 1'b1;
            state_d   = ST_IDLE;
`ifdef RX_PARITY_EN
          end else if (par_acc_q != PARITY_ODD) begin
            par_err_d = 1'b1;
            state_d   = ST_IDLE;
`endif
          end else begin
            state_d = ST_LOAD;
          end
        end
      end
      ST_LOAD: begin
        load_buffer = 1'b1;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // A load in the same cycle as a read leaves fresh data and no overrun.
    if (data_read) begin
      ready_d   = 1'b0;
      overrun_d = 1'b0;
    end
    if (state_q == ST_LOAD) begin
      ready_d = 1'b1;
      if (ready_q && !data_read) begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      prev_q    <= 1'b1;
      armed_q   <= 1'b0;
      framing_q <= 1'b0;
      overrun_q <= 1'b0;
      ready_q   <= 1'b0;
`ifdef RX_PARITY_EN
      par_acc_q <= 1'b0;
      par_err_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      prev_q    <= serial_in;
      armed_q   <= 1'b1;
      framing_q <= framing_d;
      overrun_q <= overrun_d;
      ready_q   <= ready_d;
`ifdef RX_PARITY_EN
      par_acc_q <= par_acc_d;
      par_err_q <= par_err_d;
`endif
    end
  end

  assign data_ready    = ready_q;
  assign framing_error = framing_q;
  assign overrun_error = overrun_q;
  assign rx_busy       = (state_q != ST_IDLE);
`ifdef RX_PARITY_EN
  assign parity_error  = par_err_q;
`else
  assign parity_error  = 1'b0;
`endif

endmodule

// File: tb/tb_stp_rx_ctrl.sv
// Scoreboard bench for stp_rx_ctrl at C=10, S=4, D=8: expected strobe cycles
// are queued as each frame is driven and popped as the DUT pulses.
module tb_stp_rx_ctrl;

  localparam int C      = 10;
  localparam int S      = 4;
  localparam int D      = 8;
  localparam int STOP_T = (D + 1) * C + S;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  logic serial_in = 1'b1;
  logic data_read = 1'b0;
  logic shift_enable, load_buffer, data_ready;
  logic framing_error, overrun_error, parity_error, rx_busy;

  int tests = 0;
  int fails = 0;
  int exp_shift[$];
  int exp_load[$];
  logic model_ready = 1'b0;
  logic model_ovr = 1'b0;

  stp_rx_ctrl #(
    .CLKS_PER_BIT (C),
    .SAMPLE_OFFSET(S),
    .DATA_BITS    (D)
  ) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .serial_in    (serial_in),
    .data_read    (data_read),
    .shift_enable (shift_enable),
    .load_buffer  (load_buffer),
    .data_ready   (data_ready),
    .framing_error(framing_error),
    .overrun_error(overrun_error),
    .parity_error (parity_error),
    .rx_busy      (rx_busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic line_val(input int t, input logic [7:0] data, input logic stop_bit);
    if (t < C) return 1'b0;
    if (t < (D + 1) * C) return data[t / C - 1];
    return stop_bit;
  endfunction

  function automatic logic [6:0] outs();
    return {shift_enable, load_buffer, data_ready, framing_error, overrun_error, parity_error, rx_busy};
  endfunction

  // Drives one frame starting with the edge-detect cycle now; cycle 0 follows.
  task automatic run_frame(input logic [7:0] data, input logic stop_bit, input logic read_at_load);
    logic exp_ready, exp_ovr;
    exp_ovr   = read_at_load ? 1'b0 : (model_ovr | (stop_bit & model_ready));
    exp_ready = stop_bit ? 1'b1 : (read_at_load ? 1'b0 : model_ready);
    for (int i = 0; i < D; i++) exp_shift.push_back((i + 1) * C + S);
    if (stop_bit) exp_load.push_back(STOP_T + 1);
    serial_in = 1'b0;
    for (int t = 0; t <= STOP_T + 2; t++) begin
      tick();
      serial_in = line_val(t, data, stop_bit);
      data_read = read_at_load && (t == STOP_T + 1);
      if (t == 0) begin
        tests++;
        if (rx_busy !== 1'b1 || framing_error !== 1'b0) begin
          fails++;
          $display("FAIL frame_start data=%h: busy=%b ferr=%b, required busy=1 ferr=0", data, rx_busy, framing_error);
        end
      end
      if (shift_enable) begin
        tests++;
        if (exp_shift.size() == 0 || exp_shift[0] != t) begin
          fails++;
          $display("FAIL shift_cycle data=%h: pulse at %0d, required %0d", data, t,
                   (exp_shift.size() == 0) ? -1 : exp_shift[0]);
        end
        if (exp_shift.size() != 0) void'(exp_shift.pop_front());
      end
      if (load_buffer) begin
        tests++;
        if (exp_load.size() == 0 || exp_load[0] != t) begin
          fails++;
          $display("FAIL load_cycle data=%h: pulse at %0d, required %0d", data, t,
                   (exp_load.size() == 0) ? -1 : exp_load[0]);
        end
        if (exp_load.size() != 0) void'(exp_load.pop_front());
      end
      if (t == STOP_T + 1) begin
        tests++;
        if (framing_error !== !stop_bit) begin
          fails++;
          $display("FAIL framing_flag data=%h: got %b, required %b", data, framing_error, !stop_bit);
        end
      end
      if (t == STOP_T + 2) begin
        tests++;
        if (data_ready !== exp_ready || overrun_error !== exp_ovr) begin
          fails++;
          $display("FAIL handshake data=%h: ready=%b ovr=%b, required ready=%b ovr=%b",
                   data, data_ready, overrun_error, exp_ready, exp_ovr);
        end
      end
    end
    tests++;
    if (exp_shift.size() != 0 || exp_load.size() != 0) begin
      fails++;
      $display("FAIL missing_pulses data=%h: %0d shift and %0d load left, required 0 and 0",
               data, exp_shift.size(), exp_load.size());
    end
    exp_shift.delete();
    exp_load.delete();
    model_ready = exp_ready;
    model_ovr   = exp_ovr;
    data_read   = 1'b0;
    serial_in   = 1'b1;
    $display("[TB] frame data=%h stop=%b read_at_load=%b ready=%b ovr=%b",
             data, stop_bit, read_at_load, data_ready, overrun_error);
  endtask

  task automatic read_pulse();
    data_read = 1'b1;
    tick();
    data_read = 1'b0;
    tests++;
    if (data_ready !== 1'b0 || overrun_error !== 1'b0) begin
      fails++;
      $display("FAIL read_clear: ready=%b ovr=%b, required 0 0", data_ready, overrun_error);
    end
    model_ready = 1'b0;
    model_ovr   = 1'b0;
    $display("[TB] data_read pulse ready=%b ovr=%b", data_ready, overrun_error);
  endtask

  task automatic test_reset();
    #2;
    tests++;
    if (outs() !== 7'b0) begin
      fails++;
      $display("FAIL reset_outputs: got %b, required 0000000", outs());
    end
    repeat (3) tick();
    n_rst = 1'b1;
    $display("[TB] reset released");
  endtask

  task automatic test_idle();
    int bad = 0;
    for (int t = 0; t < 100; t++) begin
      tick();
      if (outs() !== 7'b0) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL idle_line: %0d cycles with active outputs, required 0", bad);
    end
    $display("[TB] idle line 100 cycles");
  endtask

  task automatic test_good_frame();
    run_frame(8'hA5, 1'b1, 1'b0);
    read_pulse();
  endtask

  task automatic test_glitch();
    int bad = 0;
    serial_in = 1'b0;
    for (int t = 0; t <= 30; t++) begin
      tick();
      serial_in = (t < 2) ? 1'b0 : 1'b1;
      if (shift_enable || load_buffer || framing_error || overrun_error || data_ready) bad++;
      if (t == 4 || t == 5) begin
        tests++;
        if (rx_busy !== (t == 4)) begin
          fails++;
          $display("FAIL glitch_busy t=%0d: got %b, required %b", t, rx_busy, (t == 4));
        end
      end
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL glitch_effects: %0d cycles with pulses or flags, required 0", bad);
    end
    $display("[TB] glitch rejected");
  endtask

  task automatic test_framing();
    int bad = 0;
    run_frame(8'h3C, 1'b0, 1'b0);
    serial_in = 1'b0;
    for (int t = 0; t < 30; t++) begin
      tick();
      if (rx_busy) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL break_idle: busy for %0d cycles, required 0", bad);
    end
    serial_in = 1'b1;
    repeat (3) tick();
    run_frame(8'h5A, 1'b1, 1'b0);
  endtask

  task automatic test_overrun();
    run_frame(8'hC3, 1'b1, 1'b0);
    read_pulse();
  endtask

  task automatic test_back_to_back();
    run_frame(8'h0F, 1'b1, 1'b0);
    run_frame(8'hF0, 1'b1, 1'b1);
    run_frame(8'h81, 1'b1, 1'b0);
    read_pulse();
  endtask

  task automatic test_mid_reset();
    int bad = 0;
    serial_in = 1'b0;
    for (int t = 0; t <= 40; t++) tick();
    tests++;
    if (rx_busy !== 1'b1) begin
      fails++;
      $display("FAIL pre_reset_busy: got %b, required 1", rx_busy);
    end
    n_rst = 1'b0;
    #1;
    tests++;
    if (outs() !== 7'b0) begin
      fails++;
      $display("FAIL mid_reset_outputs: got %b, required 0000000", outs());
    end
    repeat (2) tick();
    n_rst = 1'b1;
    model_ready = 1'b0;
    model_ovr   = 1'b0;
    for (int t = 0; t < 20; t++) begin
      tick();
      if (rx_busy || shift_enable) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL held_low_after_reset: %0d active cycles, required 0", bad);
    end
    serial_in = 1'b1;
    repeat (2) tick();
    run_frame(8'h96, 1'b1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_idle();
    test_good_frame();
    test_glitch();
    test_framing();
    test_overrun();
    test_back_to_back();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
